mem_subword_unit: RTL and testbench

- Load/store data-path unit between the CPU memory stage and a word-wide data BRAM that has no byte enables.
- Narrows store data: sb/sh are done as a read-modify-write of the containing word.
- Extracts and sign/zero-extends lb/lbu/lh/lhu data on the way back.
- Single outstanding request; request/response handshake toward the CPU, synchronous-read BRAM port toward memory.

---
 rtl/mem_subword_unit.sv | 137 +++++++++++++
 tb/tb_mem_subword_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_subword_unit.sv
// Load/store unit for a word-wide BRAM without byte enables: sub-word stores are
// done as read-modify-write, sub-word loads are extracted and sign/zero-extended.
module mem_subword_unit #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t             state_q;
  logic               we_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        resp_rdata_q;
  logic               resp_err_q;
  logic               req_err;

  // Byte address bits above the BRAM range carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= req_size;
            uns_q        <= req_unsigned;
            addr_q       <= req_addr[ADDR_W+1:0];
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
            if (req_err)
              state_q <= RESP;
            else if (req_we && req_size == 2'b10)
              state_q <= WR;
            else
              state_q <= RD;
          end
        end
        RD:  state_q <= CAP;
        // mem_rdata belongs to the address presented during RD.
        CAP: begin
          if (we_q) begin
            wdata_q <= store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
            state_q <= WR;
          end else begin
            resp_rdata_q <= load_extend(mem_rdata, size_q, addr_q[1:0], uns_q);
            state_q      <= RESP;
          end
        end
        WR:      state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write strobe is gated by rst_n so a reset in WR never reaches memory.
  assign mem_we     = (state_q == WR) && rst_n;
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_wdata  = wdata_q;
  assign req_ready  = (state_q == IDLE) && rst_n;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_subword_unit.sv
// Bench for mem_subword_unit: directed vector table, reset-during-RMW sequence,
// and random traffic against a byte-array memory model.
module tb_mem_subword_unit;
  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  mem_subword_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM, read-before-write
  logic [31:0] bram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  int          wr_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] last_wa = '0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = 32'(mem_addr);
    end
    if (resp_valid) resp_cnt = resp_cnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nwr);
    int w0;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("ready_wait", {31'b0, req_ready}, 32'd1);
    w0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    nwr = wr_cnt - w0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_w4;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic we, logic [1:0] sz, logic uns, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] rd, logic er,
                               int lat, int nw, logic [31:0] w4);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd;
    v.exp_rd = rd; v.exp_err = er; v.exp_lat = lat; v.exp_wr = nw; v.exp_w4 = w4;
    return v;
  endfunction

  // Reference memory: plain byte array for words 0..15
  logic [7:0] ref_b [0:63];

  task automatic ref_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nw);
    int n;
    int idx;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rd = '0; nw = 0;
    idx = int'(a[5:0]);
    n = 1 << sz;
    if (er) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_b[idx + i] = wd[8*i +: 8];
      nw = 1;
      lat = (sz == 2'd2) ? 2 : 4;
    end else begin
      for (int i = 0; i < n; i++) rd = rd | (32'(ref_b[idx + i]) << (8*i));
      if (!uns && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      lat = 3;
    end
  endtask

  logic [31:0] g_rd, e_rd;
  logic        g_er, e_er;
  int          g_lat, e_lat, g_wr, e_wr;
  int          wr0, resp0;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) bram[i] = '0;
    bram[4] = 32'h8899_AABB;

    tbl.push_back(mkv(0, 2'd0, 0, 32'h11, 0, 32'hFFFF_FFAA, 0, 3, 0, 32'h8899_AABB));
    tbl.push_back(mkv(0, 2'd0, 1, 32'h11, 0, 32'h0000_00AA, 0, 3, 0, 32'h8899_AABB));
    tbl.push_back(mkv(0, 2'd1, 0, 32'h12, 0, 32'hFFFF_8899, 0, 3, 0, 32'h8899_AABB));
    tbl.push_back(mkv(0, 2'd1, 1, 32'h12, 0, 32'h0000_8899, 0, 3, 0, 32'h8899_AABB));
    tbl.push_back(mkv(0, 2'd2, 0, 32'h10, 0, 32'h8899_AABB, 0, 3, 0, 32'h8899_AABB));
    tbl.push_back(mkv(1, 2'd0, 0, 32'h13, 32'h1234_5677, 0, 0, 4, 1, 32'h7799_AABB));
    tbl.push_back(mkv(0, 2'd2, 0, 32'h10, 0, 32'h7799_AABB, 0, 3, 0, 32'h7799_AABB));
    tbl.push_back(mkv(1, 2'd2, 0, 32'h10, 32'h8899_AABB, 0, 0, 2, 1, 32'h8899_AABB));
    tbl.push_back(mkv(1, 2'd1, 0, 32'h10, 32'hCAFE_1234, 0, 0, 4, 1, 32'h8899_1234));
    tbl.push_back(mkv(0, 2'd2, 0, 32'h10, 0, 32'h8899_1234, 0, 3, 0, 32'h8899_1234));
    tbl.push_back(mkv(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 2, 1, 32'hDEAD_BEEF));
    tbl.push_back(mkv(0, 2'd2, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 3, 0, 32'hDEAD_BEEF));
    tbl.push_back(mkv(0, 2'd1, 0, 32'h11, 0, 0, 1, 1, 0, 32'hDEAD_BEEF));
    tbl.push_back(mkv(1, 2'd2, 0, 32'h12, 32'h55, 0, 1, 1, 0, 32'hDEAD_BEEF));
    tbl.push_back(mkv(0, 2'd3, 0, 32'h10, 0, 0, 1, 1, 0, 32'hDEAD_BEEF));
    tbl.push_back(mkv(0, 2'd0, 0, 32'h0001_0011, 0, 32'hFFFF_FFBE, 0, 3, 0, 32'hDEAD_BEEF));
    tbl.push_back(mkv(1, 2'd2, 0, 32'h10, 32'h8899_AABB, 0, 0, 2, 1, 32'h8899_AABB));

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_err", {31'b0, resp_err}, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 1);

    foreach (tbl[k]) begin
      do_req(tbl[k].we, tbl[k].sz, tbl[k].uns, tbl[k].a, tbl[k].wd, g_rd, g_er, g_lat, g_wr);
      chk($sformatf("vec%0d_rdata", k), g_rd, tbl[k].exp_rd);
      chk($sformatf("vec%0d_err", k), {31'b0, g_er}, {31'b0, tbl[k].exp_err});
      chk($sformatf("vec%0d_lat", k), g_lat, tbl[k].exp_lat);
      chk($sformatf("vec%0d_writes", k), g_wr, tbl[k].exp_wr);
      chk($sformatf("vec%0d_word4", k), bram[4], tbl[k].exp_w4);
      if (tbl[k].exp_wr != 0) chk($sformatf("vec%0d_waddr", k), last_wa, 32'd4);
    end

    // sb abandoned by a reset during CAP
    @(negedge clk);
    wr0 = wr_cnt; resp0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_00FF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_ready%0d", i), {31'b0, req_ready}, 0);
      chk($sformatf("midrst_we%0d", i), {31'b0, mem_we}, 0);
      chk($sformatf("midrst_valid%0d", i), {31'b0, resp_valid}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", {31'b0, req_ready}, 1);
    repeat (4) @(negedge clk);
    chk("midrst_writes", wr_cnt - wr0, 0);
    chk("midrst_resps", resp_cnt - resp0, 0);
    chk("midrst_word4", bram[4], 32'h8899_AABB);
    do_req(0, 2'd2, 0, 32'h10, 0, g_rd, g_er, g_lat, g_wr);
    chk("postrst_lw", g_rd, 32'h8899_AABB);
    chk("postrst_lat", g_lat, 3);

    // Random traffic over words 0..15, upper address bits random
    for (int w = 0; w < 16; w++) begin
      bram[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_b[4*w + b] = bram[w][8*b +: 8];
    end
    for (int t = 0; t < 300; t++) begin
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a, wd;
      we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      a = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 63));
      wd = $urandom;
      ref_op(we, sz, uns, a, wd, e_rd, e_er, e_lat, e_wr);
      do_req(we, sz, uns, a, wd, g_rd, g_er, g_lat, g_wr);
      chk($sformatf("rnd%0d_rdata", t), g_rd, e_rd);
      chk($sformatf("rnd%0d_err", t), {31'b0, g_er}, {31'b0, e_er});
      chk($sformatf("rnd%0d_lat", t), g_lat, e_lat);
      chk($sformatf("rnd%0d_writes", t), g_wr, e_wr);
    end
    for (int w = 0; w < 16; w++)
      chk($sformatf("final_word%0d", w), bram[w],
          {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
